// File: rtl/multi_alert_module.sv
// Multi-channel debounced alert monitor: one IDLE/ARMING/ALERT FSM per channel,
// plus shared first-alerter capture and a saturating alert-entry counter.
module multi_alert_module #(
   parameter int CHANNELS = 4,
   parameter int DEBOUNCE = 3,
   parameter int STICKY   = 1,
   parameter int CNT_W    = 8,
   parameter int ID_W     = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [CHANNELS-1:0] a,
   input  logic [CHANNELS-1:0] b,
   input  logic [CHANNELS-1:0] mask,
   input  logic [CHANNELS-1:0] ack,
   output logic [CHANNELS-1:0] alert,
   output logic                alert_any,
   output logic [ID_W-1:0]     first_id,
   output logic                first_valid,
   output logic [CNT_W-1:0]    event_count
);

   localparam int DW = $clog2(DEBOUNCE + 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ARMING = 2'd1,
      S_ALERT  = 2'd2
   } state_e;

   // state_q is the per-channel FSM state, kept as a named array for probing.
   state_e            state_q [CHANNELS];
   state_e            state_d [CHANNELS];
   logic [DW-1:0]     cnt_q   [CHANNELS];
   logic [DW-1:0]     cnt_d   [CHANNELS];
   logic [ID_W-1:0]   first_id_q, first_id_d;
   logic [CNT_W-1:0]  event_count_q, event_count_d;

   logic [CHANNELS-1:0] trig;
   logic [CHANNELS-1:0] entering;
   logic [CHANNELS-1:0] alert_next;
   logic [ID_W-1:0]     low_id;

   assign trig = a & b & ~mask;

   always_comb begin
      for (int i = 0; i < CHANNELS; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
         case (state_q[i])
            S_IDLE: begin
               if (trig[i]) begin
                  if (DEBOUNCE == 1) begin
                     state_d[i] = S_ALERT;
                  end else begin
                     state_d[i] = S_ARMING;
                     cnt_d[i]   = DW'(1);
                  end
               end
            end
            S_ARMING: begin
               if (!trig[i]) begin
                  state_d[i] = S_IDLE;
                  cnt_d[i]   = '0;
               end else if (int'(cnt_q[i]) + 1 == DEBOUNCE) begin
                  state_d[i] = S_ALERT;
                  cnt_d[i]   = '0;
               end else begin
                  cnt_d[i]   = cnt_q[i] + DW'(1);
               end
            end
            S_ALERT: begin
               // ack takes priority; re-arming only begins on a later edge
               if (ack[i] || (STICKY == 0 && !trig[i])) begin
                  state_d[i] = S_IDLE;
               end
            end
            default: begin
               state_d[i] = S_IDLE;
               cnt_d[i]   = '0;
            end
         endcase
      end
   end

   always_comb begin
      entering   = '0;
      alert_next = '0;
      low_id     = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         alert[i]      = (state_q[i] == S_ALERT);
         alert_next[i] = (state_d[i] == S_ALERT);
         entering[i]   = alert_next[i] && !alert[i];
      end
      // Scan downward so the lowest entering index is the one left standing.
      for (int i = CHANNELS - 1; i >= 0; i--) begin
         if (entering[i]) low_id = ID_W'(i);
      end
   end

   always_comb begin
      first_id_d    = first_id_q;
      event_count_d = event_count_q;
      if (!alert_any && |entering) begin
         first_id_d = low_id;
      end else if (!(|alert_next)) begin
         first_id_d = '0;
      end
      if (|entering && event_count_q != {CNT_W{1'b1}}) begin
         event_count_d = event_count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < CHANNELS; i++) begin
            state_q[i] <= S_IDLE;
            cnt_q[i]   <= '0;
         end
         first_id_q    <= '0;
         event_count_q <= '0;
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
         first_id_q    <= first_id_d;
         event_count_q <= event_count_d;
      end
   end

   assign alert_any   = |alert;
   assign first_valid = alert_any;
   assign first_id    = first_id_q;
   assign event_count = event_count_q;

endmodule

// File: tb/tb_multi_alert_module.sv
// Bench for multi_alert_module: a sticky 8-bit-count instance and an
// auto-clearing 2-bit-count instance driven in parallel against a reference model.
module tb_multi_alert_module;

   logic       clk;
   logic       rst;
   logic [3:0] a, b, mask, ack;

   logic [3:0] s_alert;
   logic       s_any, s_valid;
   logic [1:0] s_first;
   logic [7:0] s_count;

   logic [3:0] c_alert;
   logic       c_any, c_valid;
   logic [1:0] c_first;
   logic [1:0] c_count;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   multi_alert_module #(.CHANNELS(4), .DEBOUNCE(3), .STICKY(1), .CNT_W(8), .ID_W(2)) u_dut (
      .clk(clk), .rst(rst), .a(a), .b(b), .mask(mask), .ack(ack),
      .alert(s_alert), .alert_any(s_any), .first_id(s_first),
      .first_valid(s_valid), .event_count(s_count)
   );

   multi_alert_module #(.CHANNELS(4), .DEBOUNCE(3), .STICKY(0), .CNT_W(2), .ID_W(2)) u_ac (
      .clk(clk), .rst(rst), .a(a), .b(b), .mask(mask), .ack(ack),
      .alert(c_alert), .alert_any(c_any), .first_id(c_first),
      .first_valid(c_valid), .event_count(c_count)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   // Instance 0 = sticky / max count 255, instance 1 = auto-clear / max count 3.
   int       run  [2][4];
   bit [3:0] al   [2];
   int       first[2];
   int       cnt  [2];
   int       cmax [2] = '{255, 3};
   bit       stk  [2] = '{1'b1, 1'b0};

   logic [15:0] exp_q[$];

   task automatic model_edge();
      for (int k = 0; k < 2; k++) begin
         if (!rst) begin
            al[k] = '0; first[k] = 0; cnt[k] = 0;
            for (int i = 0; i < 4; i++) run[k][i] = 0;
         end else begin
            bit prev_any = |al[k];
            int lowest   = -1;
            for (int i = 0; i < 4; i++) begin
               bit t = a[i] & b[i] & ~mask[i];
               if (al[k][i]) begin
                  if (ack[i] || (!stk[k] && !t)) begin
                     al[k][i] = 1'b0; run[k][i] = 0;
                  end
               end else if (t) begin
                  run[k][i]++;
                  if (run[k][i] == 3) begin
                     al[k][i] = 1'b1; run[k][i] = 0;
                     if (lowest < 0) lowest = i;
                  end
               end else begin
                  run[k][i] = 0;
               end
            end
            if (!prev_any && lowest >= 0) first[k] = lowest;
            else if (al[k] == 0) first[k] = 0;
            if (lowest >= 0 && cnt[k] < cmax[k]) cnt[k]++;
         end
         exp_q.push_back({al[k], |al[k], 2'(first[k]), |al[k], 8'(cnt[k])});
      end
   endtask

   // ---------------- scoreboard ----------------
   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   task automatic compare_model();
      logic [15:0] e;
      e = exp_q.pop_front();
      check("sticky_alert", 32'(s_alert), 32'(e[15:12]));
      check("sticky_any",   32'(s_any),   32'(e[11]));
      check("sticky_first", 32'(s_first), 32'(e[10:9]));
      check("sticky_valid", 32'(s_valid), 32'(e[8]));
      check("sticky_count", 32'(s_count), 32'(e[7:0]));
      e = exp_q.pop_front();
      check("ac_alert", 32'(c_alert), 32'(e[15:12]));
      check("ac_any",   32'(c_any),   32'(e[11]));
      check("ac_first", 32'(c_first), 32'(e[10:9]));
      check("ac_valid", 32'(c_valid), 32'(e[8]));
      check("ac_count", 32'(c_count), 32'(e[1:0]));
   endtask

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      compare_model();
   endtask

   task automatic drive(input logic [3:0] ai, input logic [3:0] bi,
                        input logic [3:0] mi, input logic [3:0] ki);
      a = ai; b = bi; mask = mi; ack = ki;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      drive(4'h0, 4'h0, 4'h0, 4'h0);
      step();
      rst = 1'b1;
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      logic       rst;
      logic [3:0] a, b, mask, ack;
      logic [3:0] exp_alert;
      logic [7:0] exp_cnt;
      logic [1:0] exp_first;
   } vec_t;

   vec_t tbl[10];

   initial begin
      rst = 1'b0;
      drive(4'h0, 4'h0, 4'h0, 4'h0);

      tbl[0] = '{1'b0, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 8'd0, 2'd0};
      tbl[1] = '{1'b0, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 8'd0, 2'd0};
      tbl[2] = '{1'b1, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 8'd0, 2'd0};
      tbl[3] = '{1'b1, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 8'd0, 2'd0};
      tbl[4] = '{1'b1, 4'hF, 4'hF, 4'h0, 4'h0, 4'hF, 8'd1, 2'd0};
      tbl[5] = '{1'b1, 4'h0, 4'hF, 4'h0, 4'h0, 4'hF, 8'd1, 2'd0};
      tbl[6] = '{1'b1, 4'h0, 4'hF, 4'h0, 4'h2, 4'hD, 8'd1, 2'd0};
      tbl[7] = '{1'b1, 4'h0, 4'hF, 4'h0, 4'hF, 4'h0, 8'd1, 2'd0};
      tbl[8] = '{1'b1, 4'hF, 4'hF, 4'hF, 4'h0, 4'h0, 8'd1, 2'd0};
      tbl[9] = '{1'b1, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 8'd1, 2'd0};

      @(negedge clk);
      for (int r = 0; r < 10; r++) begin
         rst = tbl[r].rst;
         drive(tbl[r].a, tbl[r].b, tbl[r].mask, tbl[r].ack);
         step();
         check($sformatf("tbl%0d_alert", r), 32'(s_alert), 32'(tbl[r].exp_alert));
         check($sformatf("tbl%0d_count", r), 32'(s_count), 32'(tbl[r].exp_cnt));
         check($sformatf("tbl%0d_first", r), 32'(s_first), 32'(tbl[r].exp_first));
      end

      // Debounce abort on channel 2
      do_reset();
      drive(4'h4, 4'h4, 4'h0, 4'h0); step(); step();
      check("abort_after2", 32'(s_alert), 32'h0);
      drive(4'h0, 4'h4, 4'h0, 4'h0); step();
      drive(4'h4, 4'h4, 4'h0, 4'h0); step(); step();
      check("abort_after5", 32'(s_alert), 32'h0);
      step();
      check("abort_alert6", 32'(s_alert), 32'h4);
      check("abort_first", 32'(s_first), 32'd2);

      // Sticky hold, then ack with trigger still high
      do_reset();
      drive(4'h2, 4'h2, 4'h0, 4'h0); step(); step(); step();
      check("sticky_set", 32'(s_alert), 32'h2);
      drive(4'h0, 4'h2, 4'h0, 4'h0); step();
      check("sticky_hold", 32'(s_alert), 32'h2);
      check("ac_dropped", 32'(c_alert), 32'h0);
      drive(4'h2, 4'h2, 4'h0, 4'h2); step();
      check("ack_clear", 32'(s_alert), 32'h0);
      drive(4'h2, 4'h2, 4'h0, 4'h0); step(); step();
      check("rearm_wait", 32'(s_alert), 32'h0);
      step();
      check("rearm_set", 32'(s_alert), 32'h2);
      check("rearm_count", 32'(s_count), 32'd2);

      // Auto-clear on channel 3
      do_reset();
      drive(4'h8, 4'h8, 4'h0, 4'h0); step(); step(); step();
      check("ac_set", 32'(c_alert), 32'h8);
      check("ac_first3", 32'(c_first), 32'd3);
      drive(4'h8, 4'h0, 4'h0, 4'h0); step();
      check("ac_clear", 32'(c_alert), 32'h0);
      check("ac_any0", 32'(c_any), 32'h0);
      check("ac_first0", 32'(c_first), 32'd0);

      // First-alerter priority and hold
      do_reset();
      step(); step();
      drive(4'h8, 4'h8, 4'h0, 4'h0); step(); step();
      drive(4'h9, 4'h9, 4'h0, 4'h0); step();
      check("prio_e5_alert", 32'(s_alert), 32'h8);
      step(); step();
      check("prio_e7_alert", 32'(s_alert), 32'h9);
      check("prio_e7_first", 32'(s_first), 32'd3);
      drive(4'h1, 4'h1, 4'h0, 4'h8); step();
      check("prio_hold_alert", 32'(s_alert), 32'h1);
      check("prio_hold_first", 32'(s_first), 32'd3);
      drive(4'h0, 4'h0, 4'h0, 4'h1); step();
      check("prio_clear_first", 32'(s_first), 32'd0);
      check("prio_clear_valid", 32'(s_valid), 32'd0);

      // Mask blocks arming but does not clear a sticky alert
      do_reset();
      drive(4'h1, 4'h1, 4'h1, 4'h0);
      for (int i = 0; i < 5; i++) step();
      check("mask_block", 32'(s_alert), 32'h0);
      drive(4'h1, 4'h1, 4'h0, 4'h0); step(); step(); step();
      check("mask_arm", 32'(s_alert), 32'h1);
      drive(4'h1, 4'h1, 4'h1, 4'h0); step();
      check("mask_keep", 32'(s_alert), 32'h1);

      // Saturation: five separate entries on channel 0
      do_reset();
      for (int n = 0; n < 5; n++) begin
         drive(4'h1, 4'h1, 4'h0, 4'h0); step(); step(); step();
         drive(4'h0, 4'h0, 4'h0, 4'h1); step();
      end
      check("sat_ac_count", 32'(c_count), 32'd3);
      check("sat_sticky_count", 32'(s_count), 32'd5);

      // Randomized traffic with held inputs so triggers persist for several edges
      do_reset();
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 3) == 0) begin
            a = 4'($urandom_range(0, 15)) | 4'($urandom_range(0, 15));
            b = 4'($urandom_range(0, 15)) | 4'($urandom_range(0, 15));
         end
         mask = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
         ack  = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
         rst  = ($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1;
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/multi_alert_module.md
Name: multi_alert_module

Overview:
Parametrised successor to the single-channel alert latch. It monitors CHANNELS independent (a, b) trigger pairs. Each channel runs its own debounce FSM, a sticky or auto-clearing alert output, and a per-channel acknowledge. Shared logic reports the first channel to alert and keeps a saturating alert-event count for the system status path.

Parameters:
CHANNELS, 4, number of monitored channels (>=1)
DEBOUNCE, 3, consecutive qualifying cycles required before alert (>=1)
STICKY, 1, 1 = alert holds until ack; 0 = alert clears when trigger drops (ack also clears)
CNT_W, 8, width of the saturating event counter
ID_W, 2, width of first_id; must be >= clog2(CHANNELS), minimum 1

Ports:
clk  input  1  rising-edge clock, the only clock
rst  input  1  synchronous, active-low reset
a  input  CHANNELS  trigger input A, one bit per channel
b  input  CHANNELS  trigger input B, one bit per channel
mask  input  CHANNELS  1 = channel cannot start or continue arming
ack  input  CHANNELS  1 = clear that channel's alert (level, sampled each edge)
alert  output  CHANNELS  registered per-channel alert
alert_any  output  1  OR of alert
first_id  output  ID_W  index of first channel to alert in the current episode
first_valid  output  1  first_id meaningful; equals alert_any
event_count  output  CNT_W  saturating count of cycles with at least one new alert entry

Behaviour:
- All state is updated on the rising edge of clk. rst==0 at an edge forces every channel to IDLE and clears the debounce counters. It also forces alert=0, alert_any=0, first_id=0, first_valid=0 and event_count=0. rst has priority over every other input.
- Per-channel trigger: trig[i] = a[i] & b[i] & ~mask[i].
- Per-channel FSM states: IDLE, ARMING, ALERT. The debounce counter is clog2(DEBOUNCE+1) bits.
  - IDLE, trig=1: if DEBOUNCE==1, go to ALERT; otherwise go to ARMING with cnt=1.
  - IDLE, trig=0: stay in IDLE.
  - ARMING, trig=0: go to IDLE with cnt=0. Arming is never partially retained.
  - ARMING, trig=1: cnt+1. When cnt+1==DEBOUNCE, go to ALERT.
  - ALERT, STICKY=1: stay in ALERT until ack[i]=1, then go to IDLE. Trigger activity is ignored.
  - ALERT, STICKY=0: go to IDLE when ack[i]=1 or trig=0.
  - ack[i] in IDLE or ARMING has no effect.
- Latency: trig must be high at DEBOUNCE consecutive edges. alert[i] goes to 1 immediately after the DEBOUNCE-th of those edges.
- alert[i] is 1 exactly while channel i is in ALERT (registered state decode).
- Ack and trigger together: ack wins. The channel goes to IDLE. If trig is still 1, re-arming starts at the next edge and needs a full DEBOUNCE again. There is no same-edge re-entry.
- Mask does not clear an existing alert. It only blocks IDLE->ARMING and aborts ARMING.
- first_id:
  - Loaded at the edge where one or more channels enter ALERT while alert_any was 0 before that edge.
  - On simultaneous entry, the lowest index wins.
  - Held while alert_any=1, even if that channel is acked and others stay in alert.
  - Reset to 0 when alert_any returns to 0.
- event_count: increments by exactly 1 on any edge where at least one channel transitions into ALERT. It holds at all-ones once saturated. Only rst clears it.
- alert_any and first_valid are combinational ORs of the registered alert bits (no extra latency).

Test Plan:
- Reset: drive rst=0 for 2 edges with a=b=all 1s, then release. All outputs are 0 during reset. With DEBOUNCE=3, alert[0..3]=1 after the 3rd edge following release; event_count=1; first_id=0.
- Debounce abort: ch2 trig high for 2 edges, low for 1, then high for 3. No alert after the first 2 edges; alert[2]=1 only after the 6th edge; first_id=2.
- Sticky and ack: with STICKY=1, ch1 alerts, then trig drops. alert[1] stays 1. Pulse ack[1] with trig=1: alert[1]=0 next edge, then 1 again 3 edges later; event_count increments by 2 in total.
- Auto-clear: with STICKY=0, ch3 in alert, then b[3]=0. alert[3]=0 after the next edge; alert_any=0; first_id returns to 0.
- Priority and hold: ch3 alerts at edge 5 and ch0 at edge 7. first_id=3 throughout. Ack ch3: first_id stays 3 while ch0 is alerting, then 0 once ch0 is acked.
- Mask and saturation: with mask[0]=1, an active trigger never alerts, and asserting mask during ALERT keeps alert[0]=1. With CNT_W=2, five separate alert entries give event_count=3.
